// File: rtl/paint_draw_if.sv
// paint_draw_if: requester, drawer and VGA-side signals of the paint draw scheduler.
// slave = scheduler view, master = requester/drawer/VGA environment view.
interface paint_draw_if #(
    parameter int CW = 3
);
    logic          r0_req;
    logic [7:0]    r0_x, r0_y;
    logic [3:0]    r0_sx, r0_sy;
    logic [CW-1:0] r0_col;
    logic          r1_req;
    logic [7:0]    r1_x, r1_y;
    logic [3:0]    r1_sx, r1_sy;
    logic [CW-1:0] r1_col;
    logic          r0_ack, r1_ack;
    logic          drw_start;
    logic [7:0]    drw_x, drw_y;
    logic [3:0]    drw_sx, drw_sy;
    logic          drw_done;
    logic          plot;
    logic [CW-1:0] colour;
    logic          busy;
    logic          err;

    modport slave (
        input  r0_req, r0_x, r0_y, r0_sx, r0_sy, r0_col,
        input  r1_req, r1_x, r1_y, r1_sx, r1_sy, r1_col,
        input  drw_done,
        output r0_ack, r1_ack, drw_start, drw_x, drw_y, drw_sx, drw_sy,
        output plot, colour, busy, err
    );

    modport master (
        output r0_req, r0_x, r0_y, r0_sx, r0_sy, r0_col,
        output r1_req, r1_x, r1_y, r1_sx, r1_sy, r1_col,
        output drw_done,
        input  r0_ack, r1_ack, drw_start, drw_x, drw_y, drw_sx, drw_sy,
        input  plot, colour, busy, err
    );
endinterface

// File: rtl/paint_draw_scheduler.sv
// paint_draw_scheduler: shares one square-fill drawer between the brush (port 0)
// and clear/stamp (port 1) requesters, sequences the drawer start/done handshake
// and produces the VGA plot strobe and colour.
// Build option: define ROUND_ROBIN_EN to alternate ties between ports instead of
// always favouring port 0.
module paint_draw_scheduler #(
    parameter int CW      = 3,
    parameter int TIMEOUT = 300
) (
    input  logic        clk,
    input  logic        reset,
    paint_draw_if.slave bus
);
    localparam int              CNTW     = $clog2(TIMEOUT + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARM, DRAW, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [7:0]      x_q, x_d, y_q, y_d;
    logic [3:0]      sx_q, sx_d, sy_q, sy_d;
    logic [CW-1:0]   col_q, col_d;
    logic            ack0_q, ack0_d, ack1_q, ack1_d;
    logic            err_q, err_d;
    logic            pick1;
    logic            timeout;

`ifdef ROUND_ROBIN_EN
    logic last_q, last_d;

    // Tie goes to the port not granted last (last_q=1 means port 1 won last).
    always_comb pick1 = bus.r1_req && (!bus.r0_req || !last_q);
`else
    // Fixed priority: port 1 only wins while port 0 is not requesting.
    always_comb pick1 = bus.r1_req && !bus.r0_req;
`endif

    // cnt_q counts DRAW cycles already spent; this is the TIMEOUT-th DRAW cycle.
    assign timeout = (cnt_q == CNT_LAST);

    // Next-state: arbitrate and latch in IDLE, run the drawer handshake, watchdog.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        sx_d    = sx_q;
        sy_d    = sy_q;
        col_d   = col_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = err_q;
`ifdef ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.r0_req || bus.r1_req) begin
                    x_d     = pick1 ? bus.r1_x   : bus.r0_x;
                    y_d     = pick1 ? bus.r1_y   : bus.r0_y;
                    sx_d    = pick1 ? bus.r1_sx  : bus.r0_sx;
                    sy_d    = pick1 ? bus.r1_sy  : bus.r0_sy;
                    col_d   = pick1 ? bus.r1_col : bus.r0_col;
                    ack0_d  = !pick1;
                    ack1_d  = pick1;
                    err_d   = 1'b0;
                    state_d = ARM;
`ifdef ROUND_ROBIN_EN
                    last_d  = pick1;
`endif
                end
            end
            ARM: begin
                // drw_done is left over from the previous job here, so it is ignored.
                cnt_d   = '0;
                state_d = DRAW;
            end
            DRAW: begin
                if (bus.drw_done) begin
                    state_d = RELEASE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and latched-job registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            col_q   <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            sx_q    <= sx_d;
            sy_q    <= sy_d;
            col_q   <= col_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
`ifdef ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign bus.r0_ack    = ack0_q;
    assign bus.r1_ack    = ack1_q;
    assign bus.drw_x     = x_q;
    assign bus.drw_y     = y_q;
    assign bus.drw_sx    = sx_q;
    assign bus.drw_sy    = sy_q;
    assign bus.colour    = col_q;
    assign bus.err       = err_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.drw_start = (state_q == ARM) || (state_q == DRAW);
    // No strobe on the Done cycle or on the watchdog abort cycle.
    assign bus.plot      = (state_q == DRAW) && !bus.drw_done && !timeout;
endmodule

// File: tb/tb_paint_draw_scheduler.sv
// tb_paint_draw_scheduler: directed scenarios plus randomized two-port traffic,
// checked against a job-level scoreboard and a behavioural drawer model.
module tb_paint_draw_scheduler;
    localparam int CW      = 3;
    localparam int TIMEOUT = 300;

    logic clk = 1'b0;
    logic reset;

    paint_draw_if #(.CW(CW)) bus();

    paint_draw_scheduler #(.CW(CW), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Drawer model: counts start-high edges, raises Done once (sx+1)*(sy+1)
    // pixels have been offered; Done stays stale while start is low.
    bit   hang = 1'b0;
    int   dcnt = 0;
    logic drw_done_m = 1'b0;
    assign bus.drw_done = drw_done_m;

    always @(posedge clk) begin
        if (bus.drw_start) begin
            dcnt       <= dcnt + 1;
            drw_done_m <= !hang &&
                (dcnt + 1 == (int'(bus.drw_sx) + 1) * (int'(bus.drw_sy) + 1) + 1);
        end else begin
            dcnt <= 0;
        end
    end

    // Scoreboard state
    bit pend_valid = 1'b0;
    int pend_port  = 0;
    int lg         = 1;
    bit job_active = 1'b0;
    int plots      = 0;
    int last_plots = 0;
    int job_count  = 0;
    int r1_acks    = 0;
    int exp_x, exp_y, exp_sx, exp_sy, exp_col, exp_n, exp_hang;
    int grants[$];

    // Monitor: sampled mid-cycle; predicts the grant taken at the next edge.
    initial begin
        forever begin
            @(negedge clk);
            if (pend_valid) begin
                check("r0_ack", int'(bus.r0_ack), int'(pend_port == 0));
                check("r1_ack", int'(bus.r1_ack), int'(pend_port == 1));
                check("arm_start", int'(bus.drw_start), 1);
                check("arm_plot", int'(bus.plot), 0);
                check("err_clear", int'(bus.err), 0);
                job_active = 1'b1;
                plots      = 0;
                grants.push_back(pend_port);
                if (pend_port == 1) r1_acks++;
            end else if (bus.r0_ack || bus.r1_ack) begin
                check("spurious_ack", int'({bus.r0_ack, bus.r1_ack}), 0);
            end

            if (job_active) begin
                if (bus.busy) begin
                    check("drw_x", int'(bus.drw_x), exp_x);
                    check("drw_y", int'(bus.drw_y), exp_y);
                    check("drw_sx", int'(bus.drw_sx), exp_sx);
                    check("drw_sy", int'(bus.drw_sy), exp_sy);
                    if (bus.plot) begin
                        plots++;
                        check("colour", int'(bus.colour), exp_col);
                    end
                end else begin
                    check("plot_count", plots, exp_hang != 0 ? TIMEOUT - 1 : exp_n);
                    check("err_end", int'(bus.err), exp_hang);
                    check("idle_plot", int'(bus.plot), 0);
                    last_plots = plots;
                    job_count++;
                    job_active = 1'b0;
                end
            end else if (bus.plot) begin
                check("stray_plot", 1, 0);
            end

            if (reset) begin
                pend_valid = 1'b0;
                job_active = 1'b0;
                lg         = 1;
            end else if (!bus.busy && (bus.r0_req || bus.r1_req)) begin
                if (bus.r0_req && bus.r1_req) begin
`ifdef ROUND_ROBIN_EN
                    pend_port = 1 - lg;
`else
                    pend_port = 0;
`endif
                end else begin
                    pend_port = bus.r0_req ? 0 : 1;
                end
                lg         = pend_port;
                exp_x      = pend_port == 1 ? int'(bus.r1_x)   : int'(bus.r0_x);
                exp_y      = pend_port == 1 ? int'(bus.r1_y)   : int'(bus.r0_y);
                exp_sx     = pend_port == 1 ? int'(bus.r1_sx)  : int'(bus.r0_sx);
                exp_sy     = pend_port == 1 ? int'(bus.r1_sy)  : int'(bus.r0_sy);
                exp_col    = pend_port == 1 ? int'(bus.r1_col) : int'(bus.r0_col);
                exp_n      = (exp_sx + 1) * (exp_sy + 1);
                exp_hang   = int'(hang);
                pend_valid = 1'b1;
            end else begin
                pend_valid = 1'b0;
            end
        end
    end

    bit hold0 = 1'b0;

    // Advance one cycle; requesters drop req on ack and scramble their fields.
    task automatic tick();
        @(posedge clk);
        #1;
        if (bus.r0_ack && !hold0) begin
            bus.r0_req = 1'b0;
            bus.r0_x   = 8'($urandom);
            bus.r0_col = CW'($urandom);
        end
        if (bus.r1_ack) begin
            bus.r1_req = 1'b0;
            bus.r1_y   = 8'($urandom);
            bus.r1_sx  = 4'($urandom);
        end
    endtask

    task automatic req0(input int x, input int y, input int sx, input int sy, input int col);
        bus.r0_x = 8'(x); bus.r0_y = 8'(y); bus.r0_sx = 4'(sx); bus.r0_sy = 4'(sy);
        bus.r0_col = CW'(col); bus.r0_req = 1'b1;
    endtask

    task automatic req1(input int x, input int y, input int sx, input int sy, input int col);
        bus.r1_x = 8'(x); bus.r1_y = 8'(y); bus.r1_sx = 4'(sx); bus.r1_sy = 4'(sy);
        bus.r1_col = CW'(col); bus.r1_req = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        while ((bus.busy || job_active || pend_valid || bus.r0_req || bus.r1_req) && n < budget) begin
            tick();
            n++;
        end
        check(tag, int'(n < budget), 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "simulation time limit");
    end

    initial begin
        int base, seen, n, jc, ra;
        reset = 1'b1;
        bus.r0_req = 1'b0; bus.r0_x = '0; bus.r0_y = '0; bus.r0_sx = '0; bus.r0_sy = '0; bus.r0_col = '0;
        bus.r1_req = 1'b0; bus.r1_x = '0; bus.r1_y = '0; bus.r1_sx = '0; bus.r1_sy = '0; bus.r1_col = '0;
        tick(); tick(); tick();
        reset = 1'b0;

        // Reset state
        check("rst_busy", int'(bus.busy), 0);
        check("rst_plot", int'(bus.plot), 0);
        check("rst_start", int'(bus.drw_start), 0);
        check("rst_ack0", int'(bus.r0_ack), 0);
        check("rst_ack1", int'(bus.r1_ack), 0);
        check("rst_err", int'(bus.err), 0);
        check("rst_x", int'(bus.drw_x), 0);
        check("rst_sx", int'(bus.drw_sx), 0);
        check("rst_colour", int'(bus.colour), 0);

        // Single job: 2x2 square
        req0(10, 20, 1, 1, 5);
        tick();
        check("single_ack", int'(bus.r0_ack), 1);
        check("single_start", int'(bus.drw_start), 1);
        wait_idle("single_wait", 100);
        check("single_plots", last_plots, 4);
        check("single_busy", int'(bus.busy), 0);

        // Tie with both requests held
        do_reset();
        base  = grants.size();
        hold0 = 1'b1;
        req0(1, 2, 0, 0, 1);
        req1(3, 4, 1, 0, 2);
        n = 0;
`ifdef ROUND_ROBIN_EN
        while (grants.size() < base + 3 && n < 200) begin tick(); n++; end
        check("tie_wait", int'(grants.size() >= base + 3), 1);
        check("tie_g0", grants[base], 0);
        check("tie_g1", grants[base + 1], 1);
        check("tie_g2", grants[base + 2], 0);
`else
        while (grants.size() < base + 2 && n < 200) begin tick(); n++; end
        check("tie_wait", int'(grants.size() >= base + 2), 1);
        check("tie_g0", grants[base], 0);
        check("tie_g1", grants[base + 1], 0);
`endif
        hold0 = 1'b0;
        bus.r0_req = 1'b0;
        wait_idle("tie_drain", 300);

        // Max square
        req0(250, 247, 15, 15, 6);
        wait_idle("max_wait", 400);
        check("max_plots", last_plots, 256);
        check("max_err", int'(bus.err), 0);

        // Watchdog abort
        hang = 1'b1;
        req1(7, 8, 2, 2, 3);
        wait_idle("to_wait", 500);
        hang = 1'b0;
        check("to_plots", last_plots, TIMEOUT - 1);
        check("to_err", int'(bus.err), 1);
        check("to_busy", int'(bus.busy), 0);
        req0(9, 9, 0, 0, 4);
        tick();
        check("to_clear", int'(bus.err), 0);
        wait_idle("to_next", 50);
        check("to_next_plots", last_plots, 1);

        // Reset on the third plot cycle
        req0(100, 100, 3, 3, 7);
        seen = 0;
        n    = 0;
        while (seen < 3 && n < 100) begin
            tick();
            n++;
            if (bus.plot) seen++;
        end
        check("mid_seen", seen, 3);
        reset = 1'b1;
        tick();
        check("mid_plot", int'(bus.plot), 0);
        check("mid_start", int'(bus.drw_start), 0);
        check("mid_busy", int'(bus.busy), 0);
        reset = 1'b0;
        ra = r1_acks;
        req1(40, 50, 1, 2, 2);
        wait_idle("mid_next", 100);
        check("mid_next_ack", r1_acks - ra, 1);
        check("mid_next_plots", last_plots, 6);

        // Withdrawn request during an active job
        jc = job_count;
        ra = r1_acks;
        req0(5, 6, 3, 3, 1);
        tick(); tick(); tick(); tick();
        req1(60, 70, 2, 2, 5);
        tick();
        bus.r1_req = 1'b0;
        wait_idle("wd_wait", 100);
        check("wd_r1_acks", r1_acks - ra, 0);
        check("wd_jobs", job_count - jc, 1);

        // Randomized traffic on both ports
        for (int i = 0; i < 2500; i++) begin
            if (!bus.r0_req && $urandom_range(0, 7) == 0)
                req0(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (bus.r0_req && $urandom_range(0, 39) == 0)
                bus.r0_req = 1'b0;
            if (!bus.r1_req && $urandom_range(0, 7) == 0)
                req1(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
                     int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            else if (bus.r1_req && $urandom_range(0, 39) == 0)
                bus.r1_req = 1'b0;
            tick();
        end
        bus.r0_req = 1'b0;
        bus.r1_req = 1'b0;
        wait_idle("rand_drain", 200);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
